// File: rtl/board_input_ctrl.sv
// Board input peripheral: per-channel synchronise, debounce and sticky change flag,
// with a maskable level interrupt and a word-addressed CPU register window.
module board_input_ctrl #(
    parameter int unsigned       NUM_CH          = 9,
    parameter int unsigned       CH_W            = 8,
    parameter int unsigned       DEBOUNCE_CYCLES = 16,
    parameter logic [NUM_CH-1:0] INV_MASK        = 9'h100
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_CH*CH_W-1:0]   raw_in,
    input  logic [31:0]              addr,
    input  logic                     we,
    input  logic [31:0]              wdata,
    output logic [31:0]              rdata,
    output logic                     irq
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [5:0] IDX_STATUS = 6'(NUM_CH);
    localparam logic [5:0] IDX_MASK   = 6'(NUM_CH + 1);

    logic [NUM_CH-1:0][CH_W-1:0] stable_all;
    logic [NUM_CH-1:0]           accept_all;

    logic [NUM_CH-1:0] status_q, status_d;
    logic [NUM_CH-1:0] mask_q, mask_d;

    logic [5:0] idx;
    logic       status_wr;
    logic       mask_wr;
    logic       unused_bus_bits;

    assign idx       = addr[7:2];
    assign status_wr = we && (idx == IDX_STATUS);
    assign mask_wr   = we && (idx == IDX_MASK);

    assign unused_bus_bits = ^{addr[31:8], addr[1:0], wdata};

    // ------------------------------------------------------------------
    // Per-channel input path
    // ------------------------------------------------------------------
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [CH_W-1:0]  raw_adj;
        logic [CH_W-1:0]  sync1_q;
        logic [CH_W-1:0]  sync2_q;
        logic [CH_W-1:0]  stable_q, stable_d;
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic             accept;

        // Active-low channels are flipped before the synchroniser so stable is always active-high
        assign raw_adj = raw_in[i*CH_W +: CH_W] ^ {CH_W{INV_MASK[i]}};

        always_comb begin
            cnt_d    = cnt_q;
            stable_d = stable_q;
            accept   = 1'b0;
            if (sync2_q == stable_q) begin
                cnt_d = '0;
            end else if (cnt_q == CNT_LAST) begin
                stable_d = sync2_q;
                cnt_d    = '0;
                accept   = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                sync1_q  <= '0;
                sync2_q  <= '0;
                stable_q <= '0;
                cnt_q    <= '0;
            end else begin
                sync1_q  <= raw_adj;
                sync2_q  <= sync1_q;
                stable_q <= stable_d;
                cnt_q    <= cnt_d;
            end
        end

        assign stable_all[i] = stable_q;
        assign accept_all[i] = accept;
    end

    // ------------------------------------------------------------------
    // Status / mask registers
    // ------------------------------------------------------------------
    always_comb begin
        status_d = status_q;
        if (status_wr) begin
            status_d = status_q & ~wdata[NUM_CH-1:0];
        end
        // A fresh accept overrides a same-edge clear so no change is ever lost
        status_d = status_d | accept_all;

        mask_d = mask_q;
        if (mask_wr) begin
            mask_d = wdata[NUM_CH-1:0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            status_q <= '0;
            mask_q   <= '0;
        end else begin
            status_q <= status_d;
            mask_q   <= mask_d;
        end
    end

    assign irq = |(status_q & mask_q);

    // ------------------------------------------------------------------
    // Read mux
    // ------------------------------------------------------------------
    always_comb begin
        rdata = '0;
        if (idx == IDX_STATUS) begin
            rdata = 32'(status_q);
        end else if (idx == IDX_MASK) begin
            rdata = 32'(mask_q);
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (idx == 6'(i)) begin
                    rdata = 32'(stable_all[i]);
                end
            end
        end
    end

endmodule
